stream_mux_arb: RTL and testbench
=================================

// Module: stream_mux_arb
// PURPOSE
//  - Parametrised N-input, WIDTH-bit registered stream multiplexer with valid/ready handshake.
//  - Successor to the plain 16-bit 2:1 select mux; it adds selection, buffering and packet locking.
//  - Two selection modes:
//    - Fixed: the channel is chosen by the sel input.
//    - Round-robin: the channel is chosen by internal arbitration.
//  - A grant is held until the beat with last is accepted, so packets are never interleaved.
//  - Sits between datapath producers and a single shared consumer (bus or ALU operand port).
// PARAMETERS
//  WIDTH    16  data bits per channel
//  N         4  number of input channels (2..16)
//  SW        2  width of sel; must satisfy 2**SW >= N
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        per-channel valid
//  in_last    in   N        per-channel end-of-packet flag
//  in_ready   out  N        per-channel ready
//  sel        in   SW       channel select, used in fixed mode
//  mode       in   1        0 = fixed (sel), 1 = round-robin
//  out_data   out  WIDTH    registered output data
//  out_valid  out  1        registered output valid
//  out_last   out  1        registered output last
//  out_ready  in   1        downstream ready
//  grant      out  N        one-hot current grant; all zeros when none
//  busy       out  1        1 while in state LOCK
// BEHAVIOUR
//  - Clock and reset:
//    - One clock domain.
//    - rst asserted: state=IDLE, out_valid=0, out_data=0, out_last=0, rr_ptr=N-1, grant=0.
//    - Reset may arrive mid-packet: any partial packet is dropped and no output beat survives reset.
//  - Output register:
//    - Single stage; load_en = ~out_valid | out_ready.
//    - in_ready[i] = grant[i] & load_en. All other channels see in_ready=0.
//    - Transfer on channel i occurs when in_valid[i] & in_ready[i].
//    - A transfer loads out_data/out_last and sets out_valid=1 on the next edge.
//    - Latency is 1 cycle, input handshake to out_valid.
//    - Throughput is 1 beat per cycle while out_ready=1.
//    - Output accepted and no new transfer in the same cycle: out_valid->0.
//    - out_data holds its value while out_valid=1 & out_ready=0.
//  - State machine (2 states):
//    - IDLE:
//      - Grant is combinational from the candidate channel c.
//      - Fixed mode: c = sel, but only if sel < N and in_valid[sel]=1; otherwise no grant.
//      - Round-robin mode: c = first i with in_valid[i]=1, scanning rr_ptr+1 .. rr_ptr+N mod N.
//      - grant=onehot(c) when a candidate exists, else 0.
//      - A transfer may occur in the same cycle as the grant.
//      - Transfer with last=1: stay in IDLE; rr_ptr<=c.
//      - Transfer with last=0: go to LOCK, lock_ch<=c, rr_ptr<=c.
//      - No transfer (load_en=0 or no candidate): stay in IDLE; nothing is latched.
//    - LOCK:
//      - grant=onehot(lock_ch), independent of in_valid.
//      - sel and mode are ignored while in LOCK.
//      - A transfer with last=1 returns to IDLE.
//      - A stalled or idle channel holds the lock indefinitely; there is no timeout.
//  - Boundary conditions:
//    - sel >= N in fixed mode: no grant, and all in_ready=0.
//    - rr_ptr wraps N-1 -> 0.
//    - Only one valid channel: it wins every time in round-robin.
//    - Simultaneous accept+load (out_valid=1, out_ready=1, transfer): new beat loads and out_valid stays 1.
//    - A mode change in IDLE takes effect in the same cycle.
// STRUCTURE
//  - Shared package (smux_pkg): MODE_FIXED=1'b0, MODE_RR=1'b1, state encoding ST_IDLE/ST_LOCK, clog2 function.
//  - Sub-module rr_pick #(N): inputs req[N], ptr[clog2 N]; outputs onehot[N], idx, any.
//    - Purely combinational rotate-priority-encode.
//  - Top module holds the FSM, rr_ptr, lock_ch, the output register and the data mux.
// TESTING
//  1. Reset: hold rst=1 with in_valid=4'hF.
//     - Require out_valid=0, grant=0, in_ready=0.
//     - Release rst, mode=1: first grant=4'b0001.
//  2. Fixed mode, sel=2, in_valid=4'b0100, data 16'hA5A5, last=1, out_ready=1.
//     - Require out_data=16'hA5A5 and out_valid=1 exactly one cycle later.
//     - Require in_ready=4'b0100 only.
//  3. Round-robin, all in_valid=1, all last=1, out_ready=1.
//     - Require grant sequence 0001,0010,0100,1000,0001 (wrap).
//  4. Packet lock, mode=1: ch1 sends 3 beats (last on the 3rd) while ch0/ch2 are valid.
//     - Require grant=0010 for all 3 beats and busy=1 until the 3rd beat.
//     - Next grant=0100.
//  5. Backpressure: out_ready=0 for 3 cycles with out_valid=1.
//     - Require out_data stable and in_ready=0.
//     - Release: one beat per cycle, no loss or duplication.
//  6. Reset mid-packet: assert rst after beat 2 of 4.
//     - Require out_valid=0 and busy=0.
//     - Fixed mode sel=5 (N=4) after release: grant=0.

Source files
------------

// File: rtl/stream_mux_arb_pkg.sv
// Shared types and constants for the stream multiplexer/arbiter.
// Also hosts the clog2 helper used to size channel indices.
package smux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Handshake bundle between channel producers, the mux and the consumer.
// master drives channel inputs and out_ready; slave is the mux side.
interface stream_mux_arb_if #(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int SW    = 2
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_last;
   logic [N-1:0]       in_ready;
   logic [SW-1:0]      sel;
   logic               mode;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_last;
   logic               out_ready;
   logic [N-1:0]       grant;
   logic               busy;

   modport master (
      output in_data, in_valid, in_last, sel, mode, out_ready,
      input  in_ready, out_data, out_valid, out_last, grant, busy
   );

   modport slave (
      input  in_data, in_valid, in_last, sel, mode, out_ready,
      output in_ready, out_data, out_valid, out_last, grant, busy
   );
endinterface

// File: rtl/stream_mux_arb_rr_pick.sv
// Rotating-priority picker: first request after ptr, wrapping mod N.
// Purely combinational.
module rr_pick
   import smux_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [PW-1:0] idx,
   output logic          any
);

   always_comb begin
      int j;
      j   = 0;
      idx = '0;
      any = 1'b0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any = 1'b1;
            idx = PW'(j);
         end
      end
   end

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++)
         onehot[i] = any && (idx == PW'(i));
   end

endmodule

// File: rtl/stream_mux_arb.sv
// N-input registered stream mux with fixed or round-robin selection.
// A grant stays locked to one channel until its last beat is taken.
module stream_mux_arb
   import smux_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int SW    = 2
) (
   input  logic            clk,
   input  logic            rst,
   stream_mux_arb_if.slave bus
);

   localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);

   state_t           state;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    lock_ch;
   logic [PW-1:0]    rr_idx;
   logic [PW-1:0]    fx_idx;
   logic [PW-1:0]    gidx;
   logic [N-1:0]     rr_oh;
   logic [N-1:0]     grant;
   logic             rr_any;
   logic             fx_any;
   logic             gany;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] mux_data;
   logic             mux_last;
   logic [WIDTH-1:0] od;
   logic             ov;
   logic             ol;

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .req    (bus.in_valid),
      .ptr    (rr_ptr),
      .onehot (rr_oh),
      .idx    (rr_idx),
      .any    (rr_any)
   );

   // sel values at or beyond N never match a channel, so no grant
   always_comb begin
      fx_idx = '0;
      fx_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (bus.sel == SW'(i) && bus.in_valid[i]) begin
            fx_idx = PW'(i);
            fx_any = 1'b1;
         end
      end
   end

   always_comb begin
      gidx = '0;
      gany = 1'b0;
      if (!rst) begin
         unique case (1'b1)
            state == ST_LOCK: begin
               gidx = lock_ch;
               gany = 1'b1;
            end
            state == ST_IDLE && bus.mode == MODE_RR: begin
               gidx = rr_idx;
               gany = rr_any;
            end
            state == ST_IDLE && bus.mode == MODE_FIXED: begin
               gidx = fx_idx;
               gany = fx_any;
            end
         endcase
      end
   end

   always_comb begin
      grant = '0;
      for (int i = 0; i < N; i++)
         grant[i] = gany && (gidx == PW'(i));
   end

   assign load_en  = ~ov | bus.out_ready;
   assign mux_data = bus.in_data[int'(gidx)*WIDTH +: WIDTH];
   assign mux_last = bus.in_last[gidx];
   assign xfer     = gany & load_en & bus.in_valid[gidx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         rr_ptr  <= PW'(N - 1);
         lock_ch <= '0;
         od      <= '0;
         ov      <= 1'b0;
         ol      <= 1'b0;
      end else begin
         if (xfer) begin
            od <= mux_data;
            ol <= mux_last;
            ov <= 1'b1;
         end else if (bus.out_ready) begin
            ov <= 1'b0;
         end
         unique case (state)
            ST_IDLE: begin
               if (xfer) begin
                  rr_ptr <= gidx;
                  if (!mux_last) begin
                     state   <= ST_LOCK;
                     lock_ch <= gidx;
                  end
               end
            end
            ST_LOCK: begin
               if (xfer && mux_last)
                  state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = grant & {N{load_en}};
   assign bus.grant     = grant;
   assign bus.busy      = (state == ST_LOCK);
   assign bus.out_data  = od;
   assign bus.out_valid = ov;
   assign bus.out_last  = ol;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scenario bench for stream_mux_arb with a spec-level reference model.
// The model tracks a lock flag, a last-winner pointer and one output slot.
module tb_stream_mux_arb;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int SW = 3;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   stream_mux_arb_if #(.WIDTH(W), .N(N), .SW(SW)) bus ();

   stream_mux_arb #(.WIDTH(W), .N(N), .SW(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   bit          m_lock;
   int          m_lock_ch;
   int          m_ptr;
   bit          m_ov;
   logic [W-1:0] m_od;
   bit          m_ol;

   function automatic int pick();
      int j;
      if (rst) return -1;
      if (m_lock) return m_lock_ch;
      if (bus.mode == 1'b0) begin
         if (int'(bus.sel) < N && bus.in_valid[int'(bus.sel)])
            return int'(bus.sel);
         return -1;
      end
      for (int k = 1; k <= N; k++) begin
         j = (m_ptr + k) % N;
         if (bus.in_valid[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_grant();
      int c;
      logic [N-1:0] g;
      c = pick();
      g = '0;
      if (c >= 0) g[c] = 1'b1;
      return g;
   endfunction

   function automatic bit m_load_en();
      return !m_ov || bus.out_ready;
   endfunction

   always @(posedge clk or posedge rst) begin
      int c;
      if (rst) begin
         m_lock    = 0;
         m_lock_ch = 0;
         m_ptr     = N - 1;
         m_ov      = 0;
         m_od      = '0;
         m_ol      = 0;
      end else begin
         c = pick();
         if (c >= 0 && m_load_en() && bus.in_valid[c]) begin
            m_od = bus.in_data[c*W +: W];
            m_ol = bus.in_last[c];
            m_ov = 1;
            if (!m_lock) m_ptr = c;
            if (bus.in_last[c]) m_lock = 0;
            else begin
               m_lock    = 1;
               m_lock_ch = c;
            end
         end else if (bus.out_ready) begin
            m_ov = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.in_valid  = '0;
      bus.out_ready = 1'b1;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.in_valid  = 4'hF;
      bus.in_last   = 4'hF;
      bus.in_data   = '0;
      bus.mode      = 1'b1;
      bus.sel       = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      n_cmp++;
      if (bus.grant !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_grant: got %b want 0000", bus.grant);
      end
      n_cmp++;
      if (bus.in_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (bus.grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_first_grant: got %b want 0001", bus.grant);
      end
      tick();
      idle(2);
   endtask

   task automatic test_fixed();
      bus.mode          = 1'b0;
      bus.sel           = 3'd2;
      bus.in_valid      = 4'b0100;
      bus.in_last       = 4'hF;
      bus.in_data[2*W +: W] = 16'hA5A5;
      bus.out_ready     = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL fixed_in_ready: got %b want 0100", bus.in_ready);
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fixed_pre_valid: got %b want 0", bus.out_valid);
      end
      tick();
      bus.in_valid = '0;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL fixed_out: got v=%b d=%h want v=1 d=a5a5",
                  bus.out_valid, bus.out_data);
      end
      tick();
   endtask

   task automatic test_rr_wrap();
      logic [N-1:0] eg;
      for (int i = 0; i < N; i++)
         bus.in_data[i*W +: W] = 16'h1000 + 16'(i);
      bus.in_last  = 4'hF;
      bus.mode     = 1'b0;
      bus.sel      = 3'd3;
      bus.in_valid = 4'b1000;
      tick();
      bus.mode     = 1'b1;
      bus.in_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         eg = 4'b0001 << (k % 4);
         n_cmp++;
         if (bus.grant !== eg) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: got %b want %b", k, bus.grant, eg);
         end
         if (k > 0) begin
            n_cmp++;
            if (bus.out_data !== 16'h1000 + 16'((k - 1) % 4)) begin
               n_fail++;
               $display("FAIL rr_data_%0d: got %h want %h", k, bus.out_data,
                        16'h1000 + 16'((k - 1) % 4));
            end
         end
         tick();
      end
      idle(1);
   endtask

   task automatic test_lock();
      bus.mode     = 1'b1;
      bus.in_valid = 4'b0111;
      bus.in_data[0*W +: W] = 16'hEEE0;
      bus.in_data[2*W +: W] = 16'hEEE2;
      for (int b = 0; b < 3; b++) begin
         bus.in_last = {1'b1, 1'b1, (b == 2), 1'b1};
         bus.in_data[1*W +: W] = 16'hB000 + 16'(b);
         @(negedge clk);
         n_cmp++;
         if (bus.grant !== 4'b0010 || bus.busy !== (b != 0)) begin
            n_fail++;
            $display("FAIL lock_beat_%0d: got g=%b busy=%b want g=0010 busy=%b",
                     b, bus.grant, bus.busy, (b != 0));
         end
         tick();
      end
      @(negedge clk);
      n_cmp++;
      if (bus.grant !== 4'b0100 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_next: got g=%b busy=%b want g=0100 busy=0",
                  bus.grant, bus.busy);
      end
      n_cmp++;
      if (bus.out_data !== 16'hB002 || bus.out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_last_beat: got %h/%b want b002/1",
                  bus.out_data, bus.out_last);
      end
      idle(2);
   endtask

   task automatic test_backpressure();
      bus.mode      = 1'b1;
      bus.in_valid  = 4'b0001;
      bus.in_last   = 4'hF;
      bus.out_ready = 1'b1;
      bus.in_data[0*W +: W] = 16'hC000;
      tick();
      bus.out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         bus.in_data[0*W +: W] = 16'($urandom);
         @(negedge clk);
         n_cmp++;
         if (bus.out_data !== 16'hC000 || bus.out_valid !== 1'b1 ||
             bus.in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_stall_%0d: got d=%h v=%b rdy=%b want c000/1/0000",
                     s, bus.out_data, bus.out_valid, bus.in_ready);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         bus.in_data[0*W +: W] = 16'hC000 + 16'(k);
         tick();
         n_cmp++;
         if (bus.out_data !== 16'hC000 + 16'(k) || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_%0d: got %h/%b want %h/1", k,
                     bus.out_data, bus.out_valid, 16'hC000 + 16'(k));
         end
      end
      bus.in_valid = '0;
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      bus.mode      = 1'b1;
      bus.in_valid  = 4'b0001;
      bus.in_last   = 4'h0;
      bus.out_ready = 1'b1;
      bus.in_data[0*W +: W] = 16'hD001;
      tick();
      bus.in_data[0*W +: W] = 16'hD002;
      tick();
      n_cmp++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_busy_before: got %b want 1", bus.busy);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got v=%b busy=%b want 0/0",
                  bus.out_valid, bus.busy);
      end
      tick();
      rst          = 1'b0;
      bus.mode     = 1'b0;
      bus.sel      = 3'd5;
      bus.in_valid = 4'hF;
      bus.in_last  = 4'hF;
      #1;
      n_cmp++;
      if (bus.grant !== 4'b0000 || bus.in_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL sel_oob: got g=%b rdy=%b want 0000/0000",
                  bus.grant, bus.in_ready);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL sel_oob_out: got v=%b busy=%b want 0/0",
                  bus.out_valid, bus.busy);
      end
      idle(1);
   endtask

   task automatic test_random();
      logic [N-1:0] eg;
      logic [N-1:0] er;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
         bus.sel       = SW'($urandom_range(0, 7));
         bus.in_valid  = N'($urandom);
         for (int i = 0; i < N; i++) begin
            bus.in_last[i] = ($urandom_range(0, 2) == 0);
            bus.in_data[i*W +: W] = 16'($urandom);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         eg = exp_grant();
         er = eg & {N{m_load_en()}};
         n_cmp++;
         if (bus.grant !== eg || bus.in_ready !== er) begin
            n_fail++;
            $display("FAIL rand_grant c%0d: got g=%b r=%b want g=%b r=%b",
                     cyc, bus.grant, bus.in_ready, eg, er);
         end
         n_cmp++;
         if (bus.out_valid !== m_ov || bus.busy !== m_lock) begin
            n_fail++;
            $display("FAIL rand_state c%0d: got v=%b busy=%b want v=%b busy=%b",
                     cyc, bus.out_valid, bus.busy, m_ov, m_lock);
         end
         if (m_ov) begin
            n_cmp++;
            if (bus.out_data !== m_od || bus.out_last !== m_ol) begin
               n_fail++;
               $display("FAIL rand_data c%0d: got %h/%b want %h/%b",
                        cyc, bus.out_data, bus.out_last, m_od, m_ol);
            end
         end
         tick();
      end
   endtask

   initial begin
      n_cmp         = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.in_data   = '0;
      bus.in_valid  = '0;
      bus.in_last   = '0;
      bus.sel       = '0;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_fixed();
      test_rr_wrap();
      test_lock();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
